key_conditioner: RTL and testbench
==================================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable synchronized samples required before a button-vector change is accepted (legal range 2..65535).
- REQ-002: Parameter REPEAT_DELAY, default 25000000: cycles a nonzero code is held before the first auto-repeat strobe.
- REQ-003: Parameter REPEAT_RATE, default 5000000: cycles between later auto-repeat strobes.
- REQ-004: clk  input  1  single system clock; all state on its rising edge.
- REQ-005: rst  input  1  reset, asynchronous, active-high.
- REQ-006: rawKey  input  7  asynchronous push-button levels, active-high, bit n is button n.
- REQ-007: outKey  output  7  debounced key code feeding the memory-mapped keyboard input (inPKey); 0 means no key.
- REQ-008: keyStrobe  output  1  one-cycle pulse per key event, either a new press or an auto-repeat.
- REQ-009: keyHeld  output  1  high while outKey is nonzero.

Function
- REQ-010: rawKey SHALL pass through a 2-flop synchronizer per bit; no other logic SHALL sample rawKey directly.
- REQ-011: Debounce logic SHALL hold a candidate vector and a 16-bit counter, and each cycle SHALL update them as follows.
  - If the synchronized vector differs from the candidate: load the candidate and clear the counter.
  - Else, if counter = DEBOUNCE_CYCLES-1: copy the candidate into the stable vector, and the counter saturates.
  - Else: increment the counter.
- REQ-012: Encoding SHALL be priority, lowest set bit of the stable vector wins.
  - bit0='W' 87, bit1='A' 65, bit2='S' 83, bit3='D' 68, bit4=space 32, bit5='Q' 81, bit6='E' 69.
  - No bit set encodes to 0.
- REQ-013: outKey SHALL be registered and SHALL equal the encoding of the stable vector one cycle after the stable vector changes.
- REQ-014: A raw change held steady from sample k SHALL reach outKey between cycle k+DEBOUNCE_CYCLES+2 and k+DEBOUNCE_CYCLES+4 inclusive.
- REQ-015: A raw change lasting fewer than DEBOUNCE_CYCLES synchronized cycles SHALL NOT alter outKey, keyStrobe or keyHeld.
- REQ-016: The repeat FSM SHALL have exactly three states, IDLE, DELAY and REPEAT, with a 32-bit repeat counter.
- REQ-017: IDLE: when outKey goes from 0 to nonzero, the FSM SHALL pulse keyStrobe in the cycle outKey first shows the new value, clear the counter, and go to DELAY.
- REQ-018: DELAY: when the counter reaches REPEAT_DELAY-1, the FSM SHALL pulse keyStrobe, clear the counter, and go to REPEAT.
- REQ-019: REPEAT: each time the counter reaches REPEAT_RATE-1, the FSM SHALL pulse keyStrobe and clear the counter.
- REQ-020: In DELAY or REPEAT, if outKey changes to another nonzero code, the FSM SHALL pulse keyStrobe in that cycle, clear the counter, and return to DELAY.
- REQ-021: In any state, if outKey becomes 0, the FSM SHALL go to IDLE with no strobe and clear the counter.
- REQ-022: If a code change (REQ-020) and a repeat expiry occur in the same cycle, exactly one keyStrobe pulse SHALL be issued and the code change SHALL take precedence.
- REQ-023: keyStrobe SHALL never be high in two consecutive cycles.
- REQ-024: keyHeld SHALL be high exactly when outKey is nonzero, with no added latency.

Reset
- REQ-025: While rst is high, all of the following SHALL be cleared asynchronously: synchronizer flops, candidate, stable vector, both counters, outKey=0, keyStrobe=0, keyHeld=0, FSM=IDLE.
- REQ-026: Buttons held through reset release SHALL be treated as a fresh press, producing one strobe after the full debounce latency.
- REQ-027: Reset asserted mid-debounce or mid-repeat SHALL discard all progress, with no strobe on release.

Verification
(Benches use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8.)
- REQ-028: rawKey=0000001 held -> outKey=87, keyHeld=1, and a single keyStrobe, all within cycles 6..8 after first sample.
- REQ-029: rawKey bit2 pulsed high for 2 cycles -> outKey stays 0 and keyStrobe never asserts.
- REQ-030: bit4 held 60 cycles after acceptance -> strobes at acceptance, +20, +28, +36, +44, +52.
- REQ-031: bits1 and 3 held together -> outKey=65; then bit1 released and bit3 kept -> outKey=68, strobe issued, repeat timing restarts from DELAY.
- REQ-032: rst pulsed while a key is in REPEAT -> all outputs 0 immediately; key still held after release -> one strobe after 6..8 cycles, then 20-cycle delay.
- REQ-033: key released -> outKey=0 and keyHeld=0 within 6..8 cycles, with no strobe on release.

Source files
------------

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronize, debounce, priority-encode to a key
// code, and generate press/auto-repeat strobes for the keyboard input port.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] rawKey,
    output logic [6:0] outKey,
    output logic       keyStrobe,
    output logic       keyHeld
);

    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] RD_LAST = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RR_LAST = 32'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic [6:0]  sync1_q, sync2_q;
    logic [6:0]  cand_q, cand_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  stable_q, stable_d;
    logic [6:0]  outKey_q, key_d;
    logic        strobe_q, strobe_d;
    logic [31:0] rcnt_q, rcnt_d;
    state_t      state_q, state_d;

    logic key_off, key_new, exp_delay, exp_rate;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == DB_LAST) begin
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Lowest set button wins.
    always_comb begin
        if      (stable_q[0]) key_d = 7'd87;
        else if (stable_q[1]) key_d = 7'd65;
        else if (stable_q[2]) key_d = 7'd83;
        else if (stable_q[3]) key_d = 7'd68;
        else if (stable_q[4]) key_d = 7'd32;
        else if (stable_q[5]) key_d = 7'd81;
        else if (stable_q[6]) key_d = 7'd69;
        else                  key_d = 7'd0;
    end

    // FSM looks at the code about to be registered so the strobe lines up
    // with the first cycle outKey shows it.
    assign key_off   = (key_d == 7'd0);
    assign key_new   = (key_d != outKey_q);
    assign exp_delay = (rcnt_q == RD_LAST);
    assign exp_rate  = (rcnt_q == RR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            outKey_q <= '0;
            strobe_q <= 1'b0;
            rcnt_q   <= '0;
            state_q  <= S_IDLE;
        end else begin
            sync1_q  <= rawKey;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            outKey_q <= key_d;
            strobe_q <= strobe_d;
            rcnt_q   <= rcnt_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!key_off) state_d = S_DELAY;
            end
            S_DELAY: begin
                if (key_off)        state_d = S_IDLE;
                else if (key_new)   state_d = S_DELAY;
                else if (exp_delay) state_d = S_REPEAT;
            end
            S_REPEAT: begin
                if (key_off)      state_d = S_IDLE;
                else if (key_new) state_d = S_DELAY;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        strobe_d = 1'b0;
        rcnt_d   = rcnt_q + 32'd1;
        case (state_q)
            S_IDLE: begin
                rcnt_d   = '0;
                strobe_d = !key_off;
            end
            S_DELAY: begin
                if (key_off) begin
                    rcnt_d = '0;
                end else if (key_new || exp_delay) begin
                    strobe_d = 1'b1;
                    rcnt_d   = '0;
                end
            end
            S_REPEAT: begin
                if (key_off) begin
                    rcnt_d = '0;
                end else if (key_new || exp_rate) begin
                    strobe_d = 1'b1;
                    rcnt_d   = '0;
                end
            end
            default: rcnt_d = '0;
        endcase
    end

    assign outKey    = outKey_q;
    assign keyStrobe = strobe_q;
    assign keyHeld   = (outKey_q != 7'd0);

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timing.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] rawKey = '0;
    logic [6:0] outKey;
    logic       keyStrobe;
    logic       keyHeld;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int strobes[$];
    int keyseen = 0;
    int dbl     = 0;
    logic prev_strobe = 1'b0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_RATE    (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rawKey   (rawKey),
        .outKey   (outKey),
        .keyStrobe(keyStrobe),
        .keyHeld  (keyHeld)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (keyStrobe) strobes.push_back(cyc);
        if (keyStrobe && prev_strobe) dbl++;
        if (outKey != 7'd0) keyseen++;
        prev_strobe = keyStrobe;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_lat(input string tag, input int lat);
        nvec++;
        assert (lat >= 6 && lat <= 8) else begin
            nerr++;
            $error("FAIL %s: observed latency %0d expected 6..8", tag, lat);
        end
    endtask

    // Wait (bounded) for outKey to reach tgt; latency relative to sample k.
    task automatic wait_key(input logic [6:0] tgt, input int k,
                            output int lat, output int at);
        lat = -1;
        at  = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (outKey === tgt) begin
                lat = cyc - k;
                at  = cyc;
                break;
            end
        end
    endtask

    int k, lat, a, a2, n0, ks;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outKey", int'(outKey), 0);
        chk("rst_strobe", int'(keyStrobe), 0);
        chk("rst_held", int'(keyHeld), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single press of W, then release
        n0 = strobes.size();
        rawKey = 7'b0000001;
        k = cyc + 1;
        wait_key(7'd87, k, lat, a);
        chk_lat("w_press_lat", lat);
        chk("w_outKey", int'(outKey), 87);
        chk("w_held", int'(keyHeld), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("w_nstrobe", strobes.size() - n0, 1);
        chk("w_strobe_at", strobes[n0], a);
        @(negedge clk);
        n0 = strobes.size();
        rawKey = '0;
        k = cyc + 1;
        wait_key(7'd0, k, lat, a);
        chk_lat("w_release_lat", lat);
        chk("w_release_held", int'(keyHeld), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("w_release_nostrobe", strobes.size() - n0, 0);

        // Two-cycle glitch on S must be rejected
        @(negedge clk);
        n0 = strobes.size();
        ks = keyseen;
        rawKey = 7'b0000100;
        repeat (2) @(negedge clk);
        rawKey = '0;
        repeat (15) @(negedge clk);
        chk("glitch_nstrobe", strobes.size() - n0, 0);
        chk("glitch_keyseen", keyseen - ks, 0);

        // Space held: press strobe then repeats at +20,+28,+36,+44,+52
        n0 = strobes.size();
        rawKey = 7'b0010000;
        k = cyc + 1;
        wait_key(7'd32, k, lat, a);
        chk_lat("sp_press_lat", lat);
        repeat (58) @(posedge clk);
        #1;
        chk("sp_nstrobe", strobes.size() - n0, 6);
        if (strobes.size() - n0 == 6) begin
            chk("sp_s0", strobes[n0], a);
            chk("sp_s1", strobes[n0 + 1], a + 20);
            chk("sp_s2", strobes[n0 + 2], a + 28);
            chk("sp_s3", strobes[n0 + 3], a + 36);
            chk("sp_s4", strobes[n0 + 4], a + 44);
            chk("sp_s5", strobes[n0 + 5], a + 52);
        end
        @(negedge clk);
        rawKey = '0;
        k = cyc + 1;
        wait_key(7'd0, k, lat, a);
        chk_lat("sp_release_lat", lat);
        repeat (5) @(negedge clk);

        // A+D held gives A; dropping A gives D with restart from DELAY
        n0 = strobes.size();
        rawKey = 7'b0001010;
        k = cyc + 1;
        wait_key(7'd65, k, lat, a);
        chk_lat("ad_press_lat", lat);
        repeat (5) @(negedge clk);
        rawKey = 7'b0001000;
        k = cyc + 1;
        wait_key(7'd68, k, lat, a2);
        chk_lat("d_change_lat", lat);
        repeat (22) @(posedge clk);
        #1;
        chk("ad_nstrobe", strobes.size() - n0, 3);
        if (strobes.size() - n0 == 3) begin
            chk("ad_s0", strobes[n0], a);
            chk("ad_s1", strobes[n0 + 1], a2);
            chk("ad_s2", strobes[n0 + 2], a2 + 20);
        end
        @(negedge clk);
        rawKey = '0;
        k = cyc + 1;
        wait_key(7'd0, k, lat, a);
        chk_lat("ad_release_lat", lat);
        repeat (5) @(negedge clk);

        // Reset while repeating, key still held afterwards
        rawKey = 7'b0000001;
        k = cyc + 1;
        wait_key(7'd87, k, lat, a);
        chk_lat("r_press_lat", lat);
        repeat (25) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("r_async_outKey", int'(outKey), 0);
        chk("r_async_held", int'(keyHeld), 0);
        chk("r_async_strobe", int'(keyStrobe), 0);
        n0 = strobes.size();
        repeat (2) @(negedge clk);
        chk("r_during_nostrobe", strobes.size() - n0, 0);
        rst = 1'b0;
        k = cyc + 1;
        wait_key(7'd87, k, lat, a);
        chk_lat("r_fresh_lat", lat);
        repeat (22) @(posedge clk);
        #1;
        chk("r_nstrobe", strobes.size() - n0, 2);
        if (strobes.size() - n0 == 2) begin
            chk("r_s0", strobes[n0], a);
            chk("r_s1", strobes[n0 + 1], a + 20);
        end
        @(negedge clk);
        rawKey = '0;
        repeat (12) @(negedge clk);

        chk("no_back_to_back", dbl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
